// File: rtl/core_phase_sequencer_if.sv
// Phase-sequencer bus: run/stall requests in, one-hot phase enables and status out.
// The sequencer connects through the slave modport; the core-side controller uses master.
interface core_phase_sequencer_if #(
  parameter int unsigned CNTLEN = 32
);
  logic              run;
  logic              stall_fetch;
  logic              stall_decode;
  logic              stall_execute;
  logic              stall_memory;
  logic              stall_writeback;
  logic              phase_fetch;
  logic              phase_decode;
  logic              phase_execute;
  logic              phase_memory;
  logic              phase_writeback;
  logic              halted;
  logic              retire;
  logic [CNTLEN-1:0] instret;
  logic              stall_timeout;

  modport master (
    output run, stall_fetch, stall_decode, stall_execute, stall_memory, stall_writeback,
    input  phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback,
    input  halted, retire, instret, stall_timeout
  );

  modport slave (
    input  run, stall_fetch, stall_decode, stall_execute, stall_memory, stall_writeback,
    output phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback,
    output halted, retire, instret, stall_timeout
  );
endinterface

// File: rtl/core_phase_sequencer.sv
// Five-phase instruction sequencer (F/D/E/M/W) with stall hold, clean halt and retire counter.
// Optional stall watchdog enabled by defining PHASE_STALL_WATCHDOG_EN.
module core_phase_sequencer #(
  parameter int unsigned CNTLEN    = 32,
  parameter int unsigned WDT_LIMIT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  core_phase_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5
  } state_t;

  if ((WDT_LIMIT < 1) || (WDT_LIMIT > 65535)) begin : g_wdt_limit_check
    $error("WDT_LIMIT must be within 1..65535");
  end

  state_t            r_state;
  logic              r_retire;
  logic [CNTLEN-1:0] r_instret;
  logic              w_cur_stall;
  logic              w_wdt_trip;
  logic              w_run_block;

  // Only the active phase's stall matters; inactive stalls are don't-care.
  always_comb begin
    w_cur_stall = 1'b0;
    case (r_state)
      S_FETCH:     w_cur_stall = bus.stall_fetch;
      S_DECODE:    w_cur_stall = bus.stall_decode;
      S_EXECUTE:   w_cur_stall = bus.stall_execute;
      S_MEMORY:    w_cur_stall = bus.stall_memory;
      S_WRITEBACK: w_cur_stall = bus.stall_writeback;
      default:     w_cur_stall = 1'b0;
    endcase
  end

`ifdef PHASE_STALL_WATCHDOG_EN
  logic [15:0] r_wdt_cnt;
  logic        r_timeout;

  assign w_wdt_trip  = (r_wdt_cnt == 16'(WDT_LIMIT));
  assign w_run_block = r_timeout;

  // Counts consecutive held cycles in one phase; any state change restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdt_cnt <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      if (w_wdt_trip) begin
        r_timeout <= 1'b1;
      end
      if ((r_state == S_IDLE) || !w_cur_stall || w_wdt_trip) begin
        r_wdt_cnt <= 16'd0;
      end else if (r_wdt_cnt != 16'hFFFF) begin
        r_wdt_cnt <= r_wdt_cnt + 16'd1;
      end
    end
  end

  assign bus.stall_timeout = r_timeout;
`else
  assign w_wdt_trip        = 1'b0;
  assign w_run_block       = 1'b0;
  assign bus.stall_timeout = 1'b0;
`endif

  // Phase FSM; retire and instret update on the edge that leaves WRITEBACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_retire  <= 1'b0;
      r_instret <= '0;
    end else begin
      r_retire <= 1'b0;
      if (w_wdt_trip) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.run && !w_run_block) begin
              r_state <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (!w_cur_stall) r_state <= S_DECODE;
          end
          S_DECODE: begin
            if (!w_cur_stall) r_state <= S_EXECUTE;
          end
          S_EXECUTE: begin
            if (!w_cur_stall) r_state <= S_MEMORY;
          end
          S_MEMORY: begin
            if (!w_cur_stall) r_state <= S_WRITEBACK;
          end
          S_WRITEBACK: begin
            if (!w_cur_stall) begin
              r_retire  <= 1'b1;
              r_instret <= r_instret + CNTLEN'(1);
              r_state   <= bus.run ? S_FETCH : S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.phase_fetch     = (r_state == S_FETCH);
  assign bus.phase_decode    = (r_state == S_DECODE);
  assign bus.phase_execute   = (r_state == S_EXECUTE);
  assign bus.phase_memory    = (r_state == S_MEMORY);
  assign bus.phase_writeback = (r_state == S_WRITEBACK);
  assign bus.halted          = (r_state == S_IDLE);
  assign bus.retire          = r_retire;
  assign bus.instret         = r_instret;

endmodule

// File: tb/tb_core_phase_sequencer.sv
// Directed bench for core_phase_sequencer: vector table plus hand sequences for
// counter wrap, reset mid-instruction and the stall watchdog (both builds).
module tb_core_phase_sequencer;

  localparam int unsigned CNTLEN    = 4;
  localparam int unsigned WDT_LIMIT = 8;

  // Phase / stall bit order: {writeback, memory, execute, decode, fetch}
  localparam logic [4:0] P0 = 5'b00000;
  localparam logic [4:0] PF = 5'b00001;
  localparam logic [4:0] PD = 5'b00010;
  localparam logic [4:0] PE = 5'b00100;
  localparam logic [4:0] PM = 5'b01000;
  localparam logic [4:0] PW = 5'b10000;

  logic clk;
  logic rst;

  core_phase_sequencer_if #(.CNTLEN(CNTLEN)) bus ();

  core_phase_sequencer #(
    .CNTLEN    (CNTLEN),
    .WDT_LIMIT (WDT_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       run;
    logic [4:0] stall;
    logic [4:0] phase;
    logic       halted;
    logic       retire;
    logic [3:0] instret;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  function automatic void add(input logic r, input logic rn, input logic [4:0] st,
                              input logic [4:0] ph, input logic hl, input logic rt,
                              input logic [3:0] cnt);
    vec_t v;
    v.rst = r; v.run = rn; v.stall = st; v.phase = ph;
    v.halted = hl; v.retire = rt; v.instret = cnt;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rn, input logic [4:0] st);
    rst                 = r;
    bus.run             = rn;
    bus.stall_writeback = st[4];
    bus.stall_memory    = st[3];
    bus.stall_execute   = st[2];
    bus.stall_decode    = st[1];
    bus.stall_fetch     = st[0];
  endtask

  // One clock: apply inputs, take the edge, sample 1 time unit later.
  task automatic cyc(input logic r, input logic rn, input logic [4:0] st);
    drive(r, rn, st);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [4:0] ph, input logic hl,
                            input logic rt, input logic [3:0] cnt, input logic to);
    logic [4:0] act_ph;
    act_ph = {bus.phase_writeback, bus.phase_memory, bus.phase_execute,
              bus.phase_decode, bus.phase_fetch};
    check({tag, " phase"},   32'(act_ph),            32'(ph));
    check({tag, " halted"},  32'(bus.halted),        32'(hl));
    check({tag, " retire"},  32'(bus.retire),        32'(rt));
    check({tag, " instret"}, 32'(bus.instret),       32'(cnt));
    check({tag, " timeout"}, 32'(bus.stall_timeout), 32'(to));
  endtask

  logic [3:0] exp_cnt;

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 1'b0, 5'b0);

    // reset, 3 clean instructions
    add(1, 0, 5'b00000, P0, 1, 0, 0);
    add(0, 1, 5'b00000, PF, 0, 0, 0);
    add(0, 1, 5'b00000, PD, 0, 0, 0);
    add(0, 1, 5'b00000, PE, 0, 0, 0);
    add(0, 1, 5'b00000, PM, 0, 0, 0);
    add(0, 1, 5'b00000, PW, 0, 0, 0);
    add(0, 1, 5'b00000, PF, 0, 1, 1);
    add(0, 1, 5'b00000, PD, 0, 0, 1);
    add(0, 1, 5'b00000, PE, 0, 0, 1);
    add(0, 1, 5'b00000, PM, 0, 0, 1);
    add(0, 1, 5'b00000, PW, 0, 0, 1);
    add(0, 1, 5'b00000, PF, 0, 1, 2);
    add(0, 1, 5'b00000, PD, 0, 0, 2);
    add(0, 1, 5'b00000, PE, 0, 0, 2);
    add(0, 1, 5'b00000, PM, 0, 0, 2);
    add(0, 1, 5'b00000, PW, 0, 0, 2);
    add(0, 1, 5'b00000, PF, 0, 1, 3);
    // execute stalled 4 cycles, foreign stalls toggling
    add(0, 1, 5'b00000, PD, 0, 0, 3);
    add(0, 1, 5'b00000, PE, 0, 0, 3);
    add(0, 1, 5'b00101, PE, 0, 0, 3);
    add(0, 1, 5'b00110, PE, 0, 0, 3);
    add(0, 1, 5'b01101, PE, 0, 0, 3);
    add(0, 1, 5'b00100, PE, 0, 0, 3);
    add(0, 1, 5'b10001, PM, 0, 0, 3);
    add(0, 1, 5'b00101, PW, 0, 0, 3);
    add(0, 1, 5'b01110, PF, 0, 1, 4);
    // run dropped during decode: instruction completes, then idle
    add(0, 1, 5'b00000, PD, 0, 0, 4);
    add(0, 0, 5'b00000, PE, 0, 0, 4);
    add(0, 0, 5'b00000, PM, 0, 0, 4);
    add(0, 0, 5'b00000, PW, 0, 0, 4);
    add(0, 0, 5'b00000, P0, 1, 1, 5);
    add(0, 0, 5'b11111, P0, 1, 0, 5);
    add(0, 1, 5'b00000, PF, 0, 0, 5);
    // per-phase holds, run ignored mid-instruction
    add(0, 1, 5'b00001, PF, 0, 0, 5);
    add(0, 0, 5'b00000, PD, 0, 0, 5);
    add(0, 0, 5'b00010, PD, 0, 0, 5);
    add(0, 0, 5'b00000, PE, 0, 0, 5);
    add(0, 0, 5'b01000, PM, 0, 0, 5);
    add(0, 0, 5'b01000, PM, 0, 0, 5);
    add(0, 1, 5'b00000, PW, 0, 0, 5);
    add(0, 1, 5'b10000, PW, 0, 0, 5);
    add(0, 1, 5'b00000, PF, 0, 1, 6);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].run, vecs[i].stall);
      expect_out($sformatf("vec%0d", i), vecs[i].phase, vecs[i].halted,
                 vecs[i].retire, vecs[i].instret, 1'b0);
    end

    // counter wrap: 11 more instructions from 6 pass through 15 -> 0 -> 1
    exp_cnt = 4'd6;
    for (int n = 0; n < 11; n++) begin
      cyc(0, 1, 5'b0); expect_out($sformatf("wrap%0d D", n), PD, 0, 0, exp_cnt, 0);
      cyc(0, 1, 5'b0); expect_out($sformatf("wrap%0d E", n), PE, 0, 0, exp_cnt, 0);
      cyc(0, 1, 5'b0); expect_out($sformatf("wrap%0d M", n), PM, 0, 0, exp_cnt, 0);
      cyc(0, 1, 5'b0); expect_out($sformatf("wrap%0d W", n), PW, 0, 0, exp_cnt, 0);
      exp_cnt = 4'(exp_cnt + 4'd1);
      cyc(0, 1, 5'b0); expect_out($sformatf("wrap%0d F", n), PF, 0, 1, exp_cnt, 0);
      if (n == 9) check("wrap to zero", 32'(bus.instret), 32'd0);
    end
    check("wrap final", 32'(bus.instret), 32'd1);

    // reset during MEMORY abandons the instruction
    cyc(0, 1, 5'b0); expect_out("rstm D", PD, 0, 0, 1, 0);
    cyc(0, 1, 5'b0); expect_out("rstm E", PE, 0, 0, 1, 0);
    cyc(0, 1, 5'b0); expect_out("rstm M", PM, 0, 0, 1, 0);
    cyc(1, 1, 5'b0); expect_out("rstm rst", P0, 1, 0, 0, 0);
    cyc(0, 1, 5'b0); expect_out("rstm F", PF, 0, 0, 0, 0);
    cyc(0, 1, 5'b0); expect_out("rstm D2", PD, 0, 0, 0, 0);
    cyc(0, 1, 5'b0); expect_out("rstm E2", PE, 0, 0, 0, 0);
    cyc(0, 1, 5'b0); expect_out("rstm M2", PM, 0, 0, 0, 0);
    cyc(0, 1, 5'b0); expect_out("rstm W2", PW, 0, 0, 0, 0);
    cyc(0, 1, 5'b0); expect_out("rstm F2", PF, 0, 1, 1, 0);

    // stall_memory held continuously
    cyc(0, 1, PM); expect_out("wdt D", PD, 0, 0, 1, 0);
    cyc(0, 1, PM); expect_out("wdt E", PE, 0, 0, 1, 0);
    cyc(0, 1, PM); expect_out("wdt M", PM, 0, 0, 1, 0);
`ifdef PHASE_STALL_WATCHDOG_EN
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, PM); expect_out($sformatf("wdt hold%0d", k), PM, 0, 0, 1, 0);
    end
    cyc(0, 1, PM); expect_out("wdt trip", P0, 1, 0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 5'b0); expect_out($sformatf("wdt sticky%0d", k), P0, 1, 0, 1, 1);
    end
    cyc(1, 1, 5'b0); expect_out("wdt rst", P0, 1, 0, 0, 0);
    cyc(0, 1, 5'b0); expect_out("wdt rerun", PF, 0, 0, 0, 0);
`else
    for (int k = 1; k <= 30; k++) begin
      cyc(0, 1, PM); expect_out($sformatf("nowdt hold%0d", k), PM, 0, 0, 1, 0);
    end
    cyc(0, 1, 5'b0); expect_out("nowdt W", PW, 0, 0, 1, 0);
    cyc(0, 1, 5'b0); expect_out("nowdt F", PF, 0, 1, 2, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
